// File: rtl/afifo_rd_framer.sv
// Purpose: pops words from a FWFT async-FIFO read port and packs FLEN of them into a frame with a mod-2^DSIZE checksum.
// Latency: o_valid rises the cycle after the pop of the last word (or after TOUT idle cycles on a partial frame when enabled).
// Backpressure: a presented frame is held stable with popping stopped until i_ready; the accept cycle never pops.
// Optional feature: define AFIFO_RD_FRAMER_TIMEOUT_EN to flush partial frames after TOUT consecutive empty cycles.
module afifo_rd_framer #(
    parameter int DSIZE = 8,
    parameter int FLEN  = 4,
    parameter int TOUT  = 16
) (
    input  logic                      i_rclk,
    input  logic                      i_rrst_n,
    input  logic                      i_rempty,
    input  logic [DSIZE-1:0]          i_rdata,
    output logic                      o_rd,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DSIZE*FLEN-1:0]     o_frame,
    output logic [DSIZE-1:0]          o_csum,
    output logic [$clog2(FLEN+1)-1:0] o_len
);

    localparam int CW = $clog2(FLEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FLEN - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [DSIZE-1:0] sum;
    logic [DSIZE-1:0] sum_nxt;

`ifdef AFIFO_RD_FRAMER_TIMEOUT_EN
    // Idle counter only needs to reach TOUT, which is at most 255.
    localparam logic [7:0] IDLE_LAST = 8'(TOUT - 1);
    logic [7:0] idle;
`endif

    // Pop only while collecting; reset masks the strobe so no word is lost during reset.
    assign o_rd    = i_rrst_n && (state == COLLECT) && !i_rempty;

    // Running sum wraps naturally at DSIZE bits; the carry is intentionally dropped.
    assign sum_nxt = sum + i_rdata;

    // Word count and running sum double as the presented length and checksum:
    // they are frozen in HOLD, which is exactly when they are meaningful.
    assign o_len   = cnt;
    assign o_csum  = sum;

    // Frame assembly FSM: capture words in COLLECT, present and hold the frame in HOLD.
    always_ff @(posedge i_rclk) begin
        if (!i_rrst_n) begin
            state   <= COLLECT;
            cnt     <= '0;
            sum     <= '0;
            o_valid <= 1'b0;
            o_frame <= '0;
`ifdef AFIFO_RD_FRAMER_TIMEOUT_EN
            idle    <= '0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (o_rd) begin
                        for (int w = 0; w < FLEN; w++) begin
                            if (cnt == CW'(w)) begin
                                o_frame[w*DSIZE +: DSIZE] <= i_rdata;
                            end
                        end
                        sum <= sum_nxt;
                        cnt <= cnt + CW'(1);
`ifdef AFIFO_RD_FRAMER_TIMEOUT_EN
                        idle <= '0;
`endif
                        if (cnt == LAST_IDX) begin
                            state   <= HOLD;
                            o_valid <= 1'b1;
                        end
                    end
`ifdef AFIFO_RD_FRAMER_TIMEOUT_EN
                    // A started frame starving for TOUT empty cycles is flushed as-is.
                    else if ((cnt != '0) && i_rempty) begin
                        if (idle == IDLE_LAST) begin
                            state   <= HOLD;
                            o_valid <= 1'b1;
                            idle    <= '0;
                        end else begin
                            idle <= idle + 8'd1;
                        end
                    end
`endif
                end
                HOLD: begin
                    // Accept: clear everything so uncaptured words of the next frame read as zero.
                    if (i_ready) begin
                        state   <= COLLECT;
                        o_valid <= 1'b0;
                        cnt     <= '0;
                        sum     <= '0;
                        o_frame <= '0;
`ifdef AFIFO_RD_FRAMER_TIMEOUT_EN
                        idle    <= '0;
`endif
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_rd_framer.sv
// Bench for afifo_rd_framer: FWFT FIFO model feeding the DUT, expected frames queued at stimulus time
// and compared on accept; table-driven frames plus backpressure, timeout and reset sequences.
// Optional feature: AFIFO_RD_FRAMER_TIMEOUT_EN selects the timeout expectations.
module tb_afifo_rd_framer;

    localparam int DSIZE = 8;
    localparam int FLEN  = 4;
    localparam int TOUT  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rd;
    logic        valid;
    logic        ready;
    logic [31:0] frame;
    logic [7:0]  csum;
    logic [2:0]  len;

    afifo_rd_framer #(.DSIZE(DSIZE), .FLEN(FLEN), .TOUT(TOUT)) dut (
        .i_rclk  (clk),
        .i_rrst_n(rst_n),
        .i_rempty(rempty),
        .i_rdata (rdata),
        .o_rd    (rd),
        .o_valid (valid),
        .i_ready (ready),
        .o_frame (frame),
        .o_csum  (csum),
        .o_len   (len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] frame;
        logic [7:0]  csum;
        logic [2:0]  len;
    } exp_t;

    typedef struct {
        logic [7:0]  w0, w1, w2, w3;
        logic [31:0] frame;
        logic [7:0]  csum;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[$];
    vec_t       vecs[6];
    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int pops_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic drive_fifo();
        rempty = (src_q.size() == 0);
        if (src_q.size() == 0) rdata = 8'h00;
        else                   rdata = src_q[0];
    endtask

    task automatic push(input logic [7:0] w);
        src_q.push_back(w);
        drive_fifo();
    endtask

    // One clock: sample pop/accept before the edge, score accepted frames, update the FIFO model after it.
    task automatic step();
        logic pop;
        logic acc;
        exp_t e;
        #1;
        pop = rd;
        acc = rst_n && valid && ready;
        if (acc) begin
            accepts++;
            chk("sb_has_entry", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_frame", frame, e.frame);
                chk("sb_csum", csum, e.csum);
                chk("sb_len", len, e.len);
            end
        end
        @(posedge clk);
        #1;
        if (pop && src_q.size() != 0) begin
            pops_total++;
            void'(src_q.pop_front());
        end
        drive_fifo();
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        int n;
        int p0;
        exp_q.push_back('{v.frame, v.csum, 3'd4});
        p0 = pops_total;
        push(v.w0); push(v.w1); push(v.w2); push(v.w3);
        n = 0;
        while (valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("frame_latency", n, 4);
        chk("frame_pops", pops_total - p0, 4);
        chk("hold_no_pop", rd, 0);
        step();
        chk("after_accept_valid", valid, 0);
        chk("after_accept_frame", frame, 0);
        chk("after_accept_csum", csum, 0);
        chk("after_accept_len", len, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int a0;
        int cnt_v;

        vecs[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201, 8'h0A};
        vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'h03, 32'h03FFFFFF, 8'h00};
        vecs[2] = '{8'h80, 8'h80, 8'h00, 8'h00, 32'h00008080, 8'h00};
        vecs[3] = '{8'h10, 8'h20, 8'h30, 8'h40, 32'h40302010, 8'hA0};
        vecs[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hDDCCBBAA, 8'h0E};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h01, 32'h01000000, 8'h01};

        // Reset: FIFO is non-empty but no pop may happen.
        rst_n = 1'b0;
        ready = 1'b1;
        drive_fifo();
        push(8'h5A);
        repeat (3) step();
        chk("reset_rd", rd, 0);
        chk("reset_valid", valid, 0);
        chk("reset_frame", frame, 0);
        chk("reset_csum", csum, 0);
        chk("reset_len", len, 0);
        chk("reset_no_pop", pops_total, 0);
        src_q.delete();
        drive_fifo();
        rst_n = 1'b1;
        step();
        chk("post_reset_valid", valid, 0);

        // Table-driven frames with the consumer always ready.
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i]);
        end
        chk("table_accepts", accepts, 6);

        // Backpressure: two frames queued, consumer stalls 10 cycles on the first.
        ready = 1'b0;
        exp_q.push_back('{32'h04030201, 8'h0A, 3'd4});
        exp_q.push_back('{32'h08070605, 8'h1A, 3'd4});
        for (int i = 1; i <= 8; i++) push(8'(i));
        n = 0;
        while (valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("bp_first_valid", valid, 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_rd", rd, 0);
            chk("bp_valid", valid, 1);
            chk("bp_frame", frame, 32'h04030201);
            step();
        end
        chk("bp_fifo_untouched", src_q.size(), 4);
        ready = 1'b1;
        step();
        n = 1;
        while (valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("bp_gap_ge_5", (n >= 5), 1);
        step();
        chk("bp_fifo_drained", src_q.size(), 0);

        // Reset while holding a frame: it must never be presented.
        ready = 1'b0;
        push(8'h09); push(8'h0A); push(8'h0B); push(8'h0C);
        n = 0;
        while (valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("hold_rst_valid_before", valid, 1);
        a0 = accepts;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ready = 1'b1;
        chk("hold_rst_valid", valid, 0);
        chk("hold_rst_frame", frame, 0);
        repeat (5) step();
        chk("hold_rst_no_accept", accepts - a0, 0);

        // Partial frame followed by an empty FIFO.
        push(8'hAA); push(8'h55);
`ifdef AFIFO_RD_FRAMER_TIMEOUT_EN
        exp_q.push_back('{32'h000055AA, 8'hFF, 3'd2});
        n = 0;
        while (valid !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk("tout_latency", n, 2 + TOUT);
        chk("tout_len", len, 2);
        step();
        chk("tout_after_valid", valid, 0);
`else
        cnt_v = 0;
        repeat (200) begin
            step();
            if (valid) cnt_v++;
        end
        chk("no_tout_valid", cnt_v, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
`endif

        // Reset mid-frame: the two captured words are dropped.
        push(8'h11); push(8'h22);
        step(); step();
        chk("midrst_popped", src_q.size(), 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_valid", valid, 0);
        a0 = accepts;
        run_frame(vecs[0]);
        cnt_v = 0;
        repeat (20) begin
            step();
            if (valid) cnt_v++;
        end
        chk("midrst_one_frame", accepts - a0, 1);
        chk("midrst_no_extra", cnt_v, 0);

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/afifo_rd_framer.md
AFIFO_RD_FRAMER -- requirements
Module: afifo_rd_framer

Interface
REQ-001 Parameter DSIZE, default 8: width of one FIFO word in bits.
REQ-002 Parameter FLEN, default 4: number of words per frame, legal range 2..16.
REQ-003 Parameter TOUT, default 16: count of consecutive empty cycles that flushes a partial frame, legal range 2..255.
REQ-004 i_rclk  in  1: read-domain clock; all state is updated on its rising edge.
REQ-005 i_rrst_n  in  1: reset, synchronous and active-low.
REQ-006 i_rempty  in  1: FIFO empty flag.
REQ-007 i_rdata  in  DSIZE: FIFO read data, first-word-fall-through; it is valid whenever i_rempty=0.
REQ-008 o_rd  out  1: FIFO pop strobe.
REQ-009 o_valid  out  1: a frame is being presented.
REQ-010 i_ready  in  1: the downstream consumer accepts the presented frame.
REQ-011 o_frame  out  DSIZE*FLEN: frame data; word 0 sits in the LSBs.
REQ-012 o_csum  out  DSIZE: sum of the frame words, modulo 2^DSIZE.
REQ-013 o_len  out  $clog2(FLEN+1): number of valid words in the frame.

Function
REQ-014 The block SHALL have two states, COLLECT and HOLD, and SHALL leave reset in COLLECT with word count cnt=0.
REQ-015 o_rd SHALL be combinational and equal to (state==COLLECT && !i_rempty).
REQ-016 On every o_rd cycle the block SHALL perform all of the following:
- write i_rdata into o_frame word cnt;
- add i_rdata into the running sum, modulo 2^DSIZE;
- increment cnt.
REQ-017 When the pop that captures word FLEN-1 occurs, the next cycle SHALL show state=HOLD, o_valid=1, o_len=FLEN and o_csum equal to the final sum.
REQ-018 In HOLD:
- o_rd SHALL be 0;
- o_frame, o_csum and o_len SHALL remain stable until o_valid && i_ready.
REQ-019 On the cycle where o_valid && i_ready, the next cycle SHALL show:
- o_valid=0 and state=COLLECT;
- cnt=0 and sum=0;
- all o_frame words zero.
REQ-020 The accept cycle SHALL perform no pop, so back-to-back frames take at least FLEN+1 cycles each.
REQ-021 When no frame is presented, o_valid SHALL be 0; the values of o_frame, o_csum and o_len are don't-care while o_valid=0.
REQ-022 Sum arithmetic SHALL wrap at DSIZE bits and SHALL have no carry-out.
REQ-023 Words that have not been captured SHALL read as zero in o_frame.
REQ-024 A change on i_rempty while in HOLD SHALL have no effect on the block.

Reset
REQ-025 While i_rrst_n=0 at a rising edge, the next state SHALL be:
- state=COLLECT;
- cnt=0, sum=0 and idle counter=0;
- o_valid=0, o_frame=0, o_csum=0, o_len=0.
REQ-026 o_rd SHALL be forced to 0 while i_rrst_n=0.
REQ-027 A reset asserted mid-frame or in HOLD SHALL discard the partial or pending frame without presenting it.

Configuration
REQ-028 Macro AFIFO_RD_FRAMER_TIMEOUT_EN defined: the block SHALL include an idle counter with the following behaviour:
- it increments on each COLLECT cycle where cnt>0 and i_rempty=1;
- it clears on any pop and on entry to COLLECT;
- when it reaches TOUT, the next cycle SHALL show HOLD, o_valid=1, o_len=cnt and o_csum equal to the partial sum.
REQ-029 Macro AFIFO_RD_FRAMER_TIMEOUT_EN undefined: the block SHALL contain no idle counter, a partial frame SHALL wait indefinitely, and o_len SHALL always equal FLEN when o_valid=1.

Verification
REQ-030 Basic frame, FLEN=4: push 01,02,03,04 with i_ready=1 -> 4 o_rd pulses, then o_valid=1 with o_frame=0x04030201, o_csum=0x0A and o_len=4, for one cycle.
REQ-031 Checksum wrap: push FF,FF,FF,03 -> o_csum=0x00 and o_frame=0x03FFFFFF.
REQ-032 Backpressure: push 8 words with i_ready=0 for 10 cycles after o_valid -> o_rd stays 0 and frame 1 stays stable; after i_ready=1, frame 2 follows, and the gap from frame-1 accept to frame-2 o_valid is at least 5 cycles.
REQ-033 Timeout, macro defined, TOUT=16: push AA,55 then keep the FIFO empty -> o_valid=1 on the cycle after the 16th empty cycle, with o_len=2, o_frame=0x000055AA and o_csum=0xFF; with the macro undefined, o_valid stays 0 for 200 cycles.
REQ-034 Reset mid-frame: push 11,22, pulse i_rrst_n=0 for 1 cycle, then push 01,02,03,04 -> exactly one frame is presented, with o_frame=0x04030201 and o_csum=0x0A.
